// File: rtl/axis_drop_beats.sv
// AXI-Stream per-packet beat filter: drops a configurable number of leading beats
// and can optionally drop the tlast beat, moving tlast onto the last kept beat.
module axis_drop_beats #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  cfg_head_drop,
  input  logic                  cfg_drop_last,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  output logic [STAT_WIDTH-1:0] stat_drop_beats
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    idx_q, idx_d;
  logic [CNT_WIDTH-1:0]    pkt_head_q, pkt_head_d;
  logic                    pkt_dl_q, pkt_dl_d;

  logic                    h_vld_q, h_vld_d;
  logic [DATA_WIDTH-1:0]   h_data_q, h_data_d;

  logic                    o_vld_q, o_vld_d;
  logic                    o_last_q, o_last_d;
  logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;

  logic [STAT_WIDTH-1:0]   stat_q, stat_d;

  logic                    acc;
  logic [CNT_WIDTH-1:0]    head_eff;
  logic                    dl_eff;
  logic [CNT_WIDTH-1:0]    cur_idx;
  logic [CNT_WIDTH-1:0]    idx_inc;
  logic                    drop_head;
  logic                    drop_beat;
  logic                    keep;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) return v;
    else    return v + CNT_ONE;
  endfunction

  // Ready is held low while in reset so nothing can be accepted then.
  assign s_axis_tready = !rst && (!o_vld_q || m_axis_tready);
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pkt_head_q <= '0;
      pkt_dl_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_head_q <= pkt_head_d;
      pkt_dl_q   <= pkt_dl_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pkt_head_d = pkt_head_q;
    pkt_dl_d   = pkt_dl_q;
    if (acc) begin
      if (state_q == IDLE) begin
        pkt_head_d = cfg_head_drop;
        pkt_dl_d   = cfg_drop_last;
      end
      if (s_axis_tlast) begin
        state_d = IDLE;
        idx_d   = '0;
      end else if (drop_head) begin
        idx_d   = idx_inc;
        state_d = (idx_inc == head_eff) ? BODY : HEAD;
      end else begin
        state_d = BODY;
      end
    end
  end

  // The first beat of a packet is classified with the live cfg, later beats
  // with the values latched on that first beat.
  always_comb begin
    head_eff  = (state_q == IDLE) ? cfg_head_drop : pkt_head_q;
    dl_eff    = (state_q == IDLE) ? cfg_drop_last : pkt_dl_q;
    cur_idx   = (state_q == IDLE) ? '0 : idx_q;
    idx_inc   = sat_inc(cur_idx);
    drop_head = (state_q != BODY) && (cur_idx < head_eff);
    keep      = acc && !drop_head;
    drop_beat = acc && (drop_head || (dl_eff && s_axis_tlast));
  end

  always_comb begin
    o_vld_d  = o_vld_q;
    o_last_d = o_last_q;
    o_data_d = o_data_q;
    h_vld_d  = h_vld_q;
    h_data_d = h_data_q;
    stat_d   = drop_beat ? stat_q + STAT_ONE : stat_q;

    if (o_vld_q && m_axis_tready) o_vld_d = 1'b0;

    if (keep) begin
      if (!dl_eff) begin
        o_vld_d  = 1'b1;
        o_data_d = s_axis_tdata;
        o_last_d = s_axis_tlast;
      end else if (!s_axis_tlast) begin
        if (h_vld_q) begin
          o_vld_d  = 1'b1;
          o_data_d = h_data_q;
          o_last_d = 1'b0;
        end
        h_vld_d  = 1'b1;
        h_data_d = s_axis_tdata;
      end else if (h_vld_q) begin
        o_vld_d  = 1'b1;
        o_data_d = h_data_q;
        o_last_d = 1'b1;
      end
    end

    // H never carries anything across a packet boundary.
    if (acc && s_axis_tlast) h_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld_q  <= 1'b0;
      o_last_q <= 1'b0;
      o_data_q <= '0;
      h_vld_q  <= 1'b0;
      stat_q   <= '0;
    end else begin
      o_vld_q  <= o_vld_d;
      o_last_q <= o_last_d;
      o_data_q <= o_data_d;
      h_vld_q  <= h_vld_d;
      stat_q   <= stat_d;
    end
  end

  always_ff @(posedge clk) begin
    h_data_q <= h_data_d;
  end

  assign m_axis_tvalid   = o_vld_q;
  assign m_axis_tlast    = o_last_q;
  assign m_axis_tdata    = o_data_q;
  assign stat_drop_beats = stat_q;

endmodule

// File: tb/tb_axis_drop_beats.sv
// Randomized bench for axis_drop_beats against a packet-level reference model.
module tb_axis_drop_beats;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] cfg_head_drop;
  logic          cfg_drop_last;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic [SW-1:0] stat_drop_beats;

  axis_drop_beats #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_head_drop   (cfg_head_drop),
    .cfg_drop_last   (cfg_drop_last),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tvalid   (s_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .stat_drop_beats (stat_drop_beats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  int            n_cmp = 0;
  int            n_err = 0;
  longint        cyc = 0;
  beat_t         exp_q[$];
  longint        lat_q[$];
  beat_t         mon_e;
  bit            chk_lat = 1'b0;
  bit            rnd_ready = 1'b0;
  logic          ready_fix = 1'b1;
  logic [SW-1:0] exp_stat = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Output monitor: compares every handshaked output beat with the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("s_ready", 64'(s_axis_tready), 64'(!(m_axis_tvalid && !m_axis_tready)));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tdata), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, mon_e.d);
          chk("tlast", 64'(m_axis_tlast), 64'(mon_e.l));
          if (chk_lat && lat_q.size() != 0) chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
        end
      end
    end
  end

  // Packet-level model: beats [head, len) survive; with drop_last the final
  // beat is also removed and tlast moves to the beat before it.
  task automatic send_pkt(input int len, input int head, input bit dl, input bit rnd_v,
                          input bit mid_cfg);
    logic [DW-1:0] base;
    int            tmo;
    base = {$urandom, $urandom};
    for (int i = 0; i < len; i++)
      if (i >= head && (!dl || i < len - 1))
        exp_q.push_back('{d: base + DW'(i), l: (dl ? (i == len - 2) : (i == len - 1))});
    exp_stat += (len > head) ? SW'(head + int'(dl)) : SW'(len);
    cfg_head_drop = CW'(head);
    cfg_drop_last = dl;
    for (int i = 0; i < len; i++) begin
      if (rnd_v) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      s_axis_tdata  = base + DW'(i);
      s_axis_tlast  = (i == len - 1);
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      tmo = 0;
      while (!s_axis_tready && tmo < 1000) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 1000) chk("accept_timeout", 64'(1), 64'(0));
      if (chk_lat) lat_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      if (mid_cfg) begin
        cfg_head_drop = CW'($urandom_range(0, 4));
        cfg_drop_last = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    cfg_head_drop = '0;
    cfg_drop_last = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("rst_tdata", m_axis_tdata, 64'(0));
    chk("rst_stat", 64'(stat_drop_beats), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(s_axis_tready), 64'(1));
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    send_pkt(4, 0, 1'b0, 1'b0, 1'b0);
    drain();
    chk_lat = 1'b0;
    chk("stat_t1", 64'(stat_drop_beats), 64'(exp_stat));

    send_pkt(4, 0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("stat_t2", 64'(stat_drop_beats), 64'(exp_stat));

    send_pkt(5, 2, 1'b1, 1'b0, 1'b0);
    drain();
    chk("stat_t3", 64'(stat_drop_beats), 64'(exp_stat));

    send_pkt(3, 3, 1'b0, 1'b0, 1'b0);
    drain();
    chk("stat_t4a", 64'(stat_drop_beats), 64'(exp_stat));
    send_pkt(2, 0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("stat_t4b", 64'(stat_drop_beats), 64'(exp_stat));

    rnd_ready = 1'b1;
    for (int p = 0; p < 200; p++)
      send_pkt($urandom_range(1, 8), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    drain();
    rnd_ready = 1'b0;
    ready_fix = 1'b1;
    drain();
    chk("stat_t5", 64'(stat_drop_beats), 64'(exp_stat));

    send_pkt(5, 1, 1'b1, 1'b0, 1'b1);
    drain();
    chk("stat_t6_midcfg", 64'(stat_drop_beats), 64'(exp_stat));

    // Stall the output, leave a packet half-sent, then reset.
    ready_fix = 1'b0;
    @(posedge clk);
    #1;
    cfg_head_drop = '0;
    cfg_drop_last = 1'b0;
    s_axis_tdata  = 64'hA5A5_0000_0000_0001;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tdata = 64'hA5A5_0000_0000_0002;
    @(negedge clk);
    chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
    chk("stall_ready", 64'(s_axis_tready), 64'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("midrst_tlast", 64'(m_axis_tlast), 64'(0));
    chk("midrst_tdata", m_axis_tdata, 64'(0));
    chk("midrst_stat", 64'(stat_drop_beats), 64'(0));
    s_axis_tvalid = 1'b0;
    exp_stat = '0;
    @(negedge clk);
    rst = 1'b0;
    ready_fix = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(3, 0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("stat_t6_after_rst", 64'(stat_drop_beats), 64'(exp_stat));
    send_pkt(4, 1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("stat_t6_final", 64'(stat_drop_beats), 64'(exp_stat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
